// File: rtl/dff_write_arbiter.sv
// rtl/dff_write_arbiter.sv - round-robin write arbiter and sequencer for a shared register
//
// Purpose: shares one WIDTH-bit register among N requesters. One requester at
// a time is granted, its data is loaded into the register, and it is acknowledged.
// This block is the only agent that loads the shared register.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   req       per-requester request, bit i is requester i
//   d_bus     requester data, requester i at [i*WIDTH +: WIDTH]
//   grant     one-hot grant, registered
//   ack       one-hot write acknowledge, registered, one-cycle pulse
//   q         shared register contents
//   busy      high while a transaction is in flight (GRANT or WRITE)
//   wr_count  completed writes, wraps 255 -> 0
module dff_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] d_bus,
    output logic [N-1:0]       grant,
    output logic [N-1:0]       ack,
    output logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic [7:0]         wr_count
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] w;
    logic [PW-1:0] sel;
    logic          found;
    int            idx;

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] i);
        return {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

    // Round-robin search: first set request bit starting at ptr, wrapping mod N.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            w        <= '0;
            grant    <= '0;
            ack      <= '0;
            q        <= '0;
            wr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (found) begin
                        w     <= sel;
                        grant <= onehot(sel);
                        state <= GRANT;
                    end else begin
                        grant <= '0;
                    end
                end
                GRANT: begin
                    grant <= '0;
                    // A requester that withdrew during GRANT aborts the
                    // transaction: no write, no ack, priority left untouched.
                    if (req[w]) begin
                        q        <= d_bus[w*WIDTH +: WIDTH];
                        ack      <= onehot(w);
                        ptr      <= (w == PW'(N-1)) ? '0 : w + 1'b1;
                        wr_count <= wr_count + 8'd1;
                        state    <= WRITE;
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    ack   <= '0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
